// File: rtl/seq_cond_pkg.sv
// Shared types and defaults for the bit conditioner: FSM encoding and timing constants.
package seq_cond_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CAPTURE      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // 20 ms at 12 MHz, and the legacy clock-divider step period
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 240000;
    localparam int unsigned TICK_DIV_DEF        = 20000000;
    localparam int unsigned CNT_W_DEF           = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a hold-time debouncer for one raw asynchronous input.
module debounce_filter
    import seq_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [DB_W-1:0] r_cnt;

    // Level flips only after the synchronised input has disagreed for DEBOUNCE_CYCLES edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/seq_bit_conditioner.sv
// Turns a raw bit switch plus step button (or an auto tick) into one clean serial bit
// with a single-cycle valid strobe for the downstream sequence detector.
module seq_bit_conditioner
    import seq_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_in,
    input  logic             btn_in,
    input  logic             auto_en,
    output logic             x,
    output logic             x_valid,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy
);

    localparam int unsigned     TK_W    = cnt_width(TICK_DIV);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    logic             w_sw_level;
    logic             w_btn_level;
    logic             w_tick;
    logic             w_capture;
    state_t           w_state_next;

    logic             r_btn_prev;
    logic             r_btn_rise;
    logic [TK_W-1:0]  r_tick_cnt;
    state_t           r_state;
    logic             r_x;
    logic             r_x_valid;
    logic [CNT_W-1:0] r_bit_count;
    logic             r_busy;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (sw_in),
        .o_level (w_sw_level)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (btn_in),
        .o_level (w_btn_level)
    );

    // Free-running tick only while auto mode is on; dropping auto_en rewinds it
    always_ff @(posedge clk) begin
        if (!rst_n || !auto_en) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TK_W'(1);
        end
    end

    assign w_tick = auto_en && (r_tick_cnt == TK_LAST);

    // Registered rising edge of the debounced button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_prev <= 1'b0;
            r_btn_rise <= 1'b0;
        end else begin
            r_btn_prev <= w_btn_level;
            r_btn_rise <= w_btn_level && !r_btn_prev;
        end
    end

    // Events seen outside IDLE are simply dropped
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_btn_rise || w_tick) begin
                    w_state_next = CAPTURE;
                    w_capture    = 1'b1;
                end
            end
            CAPTURE: begin
                w_state_next = w_btn_level ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                if (!w_btn_level) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= 1'b0;
            r_x_valid   <= 1'b0;
            r_bit_count <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_x_valid <= w_capture;
            r_busy    <= (w_state_next != IDLE);
            if (w_capture) begin
                r_x         <= w_sw_level;
                r_bit_count <= r_bit_count + CNT_W'(1);
            end
        end
    end

    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign bit_count = r_bit_count;
    assign busy      = r_busy;

endmodule

// File: doc/seq_bit_conditioner.md
Name: seq_bit_conditioner

Overview:
- Input stage directly upstream of the sequence-detector FSM on the Vaman board.
- Turns a raw bit switch plus a raw step push-button into one clean serial bit `x` with a single-cycle `x_valid` strobe. The detector consumes one bit per strobe.
- Optional auto mode replaces the button with a slow internal tick, the same role as the existing clock divider.
- Counts delivered bits for display and debug.

Parameters:
- DEBOUNCE_CYCLES, 240000: cycles a synchronised input must hold a new level before it is accepted (20 ms at 12 MHz).
- TICK_DIV, 20000000: auto-mode tick period in clk cycles.
- CNT_W, 8: width of `bit_count`.

Ports:
- clk  in  1  system clock (Sys_Clk0).
- rst_n  in  1  synchronous, active-low reset.
- sw_in  in  1  raw, asynchronous bit switch.
- btn_in  in  1  raw, asynchronous step button, high = pressed.
- auto_en  in  1  level; 1 = tick-driven capture.
- x  out  1  captured bit, registered.
- x_valid  out  1  one-cycle strobe; `x` is new in the same cycle.
- bit_count  out  CNT_W  number of bits delivered, wraps.
- busy  out  1  high while in CAPTURE or WAIT_RELEASE.

Behaviour:
- Reset: one clock, one reset.
  - Reset is synchronous and active-low, sampled on `posedge clk`.
  - While `rst_n = 0` at an edge, everything is cleared: `x = 0`, `x_valid = 0`, `bit_count = 0`, `busy = 0`, FSM in IDLE, synchronisers 0, debounced levels 0, all counters 0.
  - Reset mid-operation (including in CAPTURE) aborts with no strobe.
  - If the button is still held after reset, it is re-debounced 0→1, which produces one capture.
- Synchroniser: `sw_in` and `btn_in` each pass through 2 flops before any other use.
- Debounce (per input):
  - Counter increments while the synchronised level differs from the stable level.
  - It clears when the two levels agree.
  - When the counter reaches DEBOUNCE_CYCLES−1 and the levels still differ, the stable level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES leave the stable level unchanged.
  - Raw-to-debounced latency: DEBOUNCE_CYCLES + 2 cycles.
- Button edge: `btn_rise` = debounced button is 1 now and was 0 on the previous cycle; asserted for one cycle.
- Tick:
  - Counter runs 0..TICK_DIV−1 only while `auto_en = 1`; it is held at 0 while `auto_en = 0`.
  - `tick` is asserted for one cycle when the count equals TICK_DIV−1, then the count wraps to 0.
- FSM states: IDLE, CAPTURE, WAIT_RELEASE.
  - IDLE → CAPTURE when `btn_rise = 1`, or when `auto_en = 1` and `tick = 1`.
    - If both occur in the same cycle, exactly one capture happens.
    - On that edge: `x <= debounced sw`, `x_valid <= 1`, `bit_count <= bit_count + 1` (modulo 2^CNT_W, so 255 → 0).
  - CAPTURE lasts exactly 1 cycle; `x_valid` is high only in CAPTURE.
    - Next state is WAIT_RELEASE if the debounced button is 1, else IDLE.
  - WAIT_RELEASE → IDLE when the debounced button reads 0.
- Dropped events:
  - Ticks and button edges arriving in CAPTURE or WAIT_RELEASE are discarded, not queued.
  - The tick counter keeps running during those states.
- `x` holds its last value between strobes.
- Changes to `sw_in` never cause a strobe on their own.
- Latency: a raw button press strobes `x_valid` DEBOUNCE_CYCLES + 4 cycles after the press.
- `auto_en` may toggle at any time. Clearing it resets the tick counter but leaves the FSM state unchanged.

Decomposition:
- Package `seq_cond_pkg`:
  - FSM state encoding: IDLE = 2'd0, CAPTURE = 2'd1, WAIT_RELEASE = 2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default constants for DEBOUNCE_CYCLES and TICK_DIV.
- Sub-module `debounce_filter`:
  - Contains the 2-flop synchroniser, the debounce counter and the stable level.
  - Instantiated twice, once for the switch and once for the button.
- Tick counter, edge detect, FSM and output registers live in the top module.

Test Plan (DEBOUNCE_CYCLES = 4, TICK_DIV = 8, CNT_W = 8):
1. Reset, then `sw_in = 1` held 20 cycles, then `btn_in` pulsed high 10 cycles → exactly one `x_valid` pulse 8 cycles after the btn rise with `x = 1`; `bit_count = 1`; `busy` stays high until the debounced release.
2. `btn_in` glitches of 1, 2 and 3 cycles separated by 5 low cycles → no `x_valid`; `bit_count` stays 0.
3. `auto_en = 1`, `sw_in = 0`, held for 40 cycles → `x_valid` every 8 cycles (5 pulses), all with `x = 0`; `bit_count = 5`. Setting `auto_en = 0` stops the pulses.
4. Tick and `btn_rise` aligned in the same cycle → one strobe only; `bit_count` increments by 1. Button held across the next two ticks → those ticks are dropped (no strobe until release, then the next tick strobes).
5. 256 captures → `bit_count` wraps 255 → 0, with `x_valid` still asserted on the wrapping capture.
6. `rst_n = 0` asserted during CAPTURE with the button held → `x_valid`, `x`, `bit_count` and `busy` are 0 at the reset edge. After release of reset, one capture occurs DEBOUNCE_CYCLES + 4 cycles later.
